// File: rtl/gr8ram_pkg.sv
// rtl/gr8ram_pkg.sv - shared constants and loader state type
package gr8ram_pkg;

  // Flash READ command: opcode followed by a 24-bit address, data streams out
  localparam logic [7:0]  SPI_READ       = 8'h03;

  // SDRAM window the controller serves ROM reads from (Addr[24:23] = 2'b10)
  localparam logic [24:0] ROM_SDRAM_BASE = 25'h1000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DRAIN
  } loader_state_t;

endpackage

// File: rtl/spi_shift.sv
// rtl/spi_shift.sv - SPI mode-0 clock generator with command and receive shifters
module spi_shift (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        run,
  input  logic        stall,
  input  logic        miso,
  output logic        fck,
  output logic        mosi,
  output logic        fall,
  output logic [4:0]  bit_cnt,
  output logic [7:0]  rx_next,
  output logic [7:0]  rx_byte
);

  logic [31:0] tx;
  logic [7:0]  rx;

  // A falling FCK edge happens on this clock when running, not stalled, and FCK is high.
  // The stall only ever gates the low phase, so the high phase is never stretched.
  assign fall    = run && !stall && fck;
  assign mosi    = tx[31];
  assign rx_next = {rx[6:0], miso};
  assign rx_byte = rx;

  // FCK toggles every clock while running; both shifters and the bit counter advance on the falling edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fck     <= 1'b0;
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      fck     <= 1'b0;
      tx      <= load_word;
      bit_cnt <= '0;
    end else if (run && !stall) begin
      fck <= !fck;
      if (fck) begin
        tx      <= {tx[30:0], 1'b0};
        rx      <= rx_next;
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/flash_sdram_loader.sv
// rtl/flash_sdram_loader.sv - boot copier from SPI flash into the SDRAM byte write port
module flash_sdram_loader
  import gr8ram_pkg::*;
#(
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter logic [23:0] LEN        = 24'd4096,
  parameter logic [24:0] DST_BASE   = ROM_SDRAM_BASE
) (
  input  logic        C25M,
  input  logic        nRES,
  input  logic        start,
  output logic        nFCS,
  output logic        FCK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [24:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done
);

  generate
    if (LEN == 24'd0) begin : g_len_zero
      $error("flash_sdram_loader: LEN must be nonzero");
    end
  endgenerate

  loader_state_t state_q, state_d;

  logic        spi_load, spi_run, spi_stall, spi_fall;
  logic [4:0]  bit_cnt;
  logic [7:0]  rx_next, rx_byte;
  logic        pending;
  logic [23:0] byte_cnt;
  logic        slot_free, byte_done, last_byte, finish;

  // The output slot can take a byte this edge if it is empty or being accepted
  assign slot_free = !wr_valid || wr_ready;
  // A completed byte waiting for the slot stays in the receive shifter, so FCK must hold low
  assign spi_stall = pending && !slot_free;
  assign spi_load  = (state_q == ST_IDLE) && start;
  assign spi_run   = (state_q == ST_CMD) || (state_q == ST_DATA);
  assign byte_done = (state_q == ST_DATA) && spi_fall && (bit_cnt[2:0] == 3'd7);
  assign last_byte = (byte_cnt == LEN - 24'd1);

  spi_shift u_spi (
    .clk       (C25M),
    .resetn    (nRES),
    .load      (spi_load),
    .load_word ({SPI_READ, FLASH_BASE}),
    .run       (spi_run),
    .stall     (spi_stall),
    .miso      (MISO),
    .fck       (FCK),
    .mosi      (MOSI),
    .fall      (spi_fall),
    .bit_cnt   (bit_cnt),
    .rx_next   (rx_next),
    .rx_byte   (rx_byte)
  );

  // State register
  always_ff @(posedge C25M) begin
    if (!nRES) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: command for 32 falling edges, then bytes until LEN, then drain the slot
  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CMD;
      ST_CMD:   if (spi_fall && (bit_cnt == 5'd31)) state_d = ST_DATA;
      ST_DATA:  if (byte_done && last_byte) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!pending && slot_free) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output slot, destination address, byte counter and status flags
  always_ff @(posedge C25M) begin
    if (!nRES) begin
      nFCS     <= 1'b1;
      wr_valid <= 1'b0;
      wr_addr  <= DST_BASE;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pending  <= 1'b0;
      byte_cnt <= '0;
    end else begin
      if (spi_load) begin
        nFCS     <= 1'b0;
        busy     <= 1'b1;
        done     <= 1'b0;
        wr_addr  <= DST_BASE;
        byte_cnt <= '0;
      end
      if (wr_valid && wr_ready) begin
        wr_addr  <= wr_addr + 25'd1;
        wr_valid <= 1'b0;
      end
      if (byte_done) begin
        byte_cnt <= byte_cnt + 24'd1;
        if (slot_free) begin
          wr_data  <= rx_next;
          wr_valid <= 1'b1;
        end else begin
          pending  <= 1'b1;
        end
      end
      if (pending && slot_free) begin
        wr_data  <= rx_byte;
        wr_valid <= 1'b1;
        pending  <= 1'b0;
      end
      if (finish) begin
        nFCS <= 1'b1;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flash_sdram_loader.sv
// tb/tb_flash_sdram_loader.sv - scoreboard bench for flash_sdram_loader
module tb_flash_sdram_loader;

  typedef struct {
    int          rises;
    int          falls;
    logic [31:0] cmd;
    logic        fck_d;
    logic        miso;
  } flash_t;

  logic        clk   = 1'b0;
  logic        nres  = 1'b0;
  logic        start = 1'b0;

  logic        fcs0, fck0, mosi0, valid0, busy0, done0;
  logic        miso0  = 1'b0;
  logic        ready0 = 1'b1;
  logic [24:0] addr0;
  logic [7:0]  data0;

  logic        fcs1, fck1, mosi1, valid1, busy1, done1;
  logic        miso1  = 1'b0;
  logic        ready1 = 1'b1;
  logic [24:0] addr1;
  logic [7:0]  data1;

  int checks = 0;
  int passes = 0;
  int cur    = 0;
  int viol;

  logic [32:0] exp0[$];
  logic [32:0] exp1[$];
  flash_t      fl0, fl1;

  flash_sdram_loader #(
    .FLASH_BASE(24'h012345), .LEN(24'd4), .DST_BASE(25'h1000000)
  ) u0 (
    .C25M(clk), .nRES(nres), .start(start),
    .nFCS(fcs0), .FCK(fck0), .MOSI(mosi0), .MISO(miso0),
    .wr_valid(valid0), .wr_ready(ready0), .wr_addr(addr0), .wr_data(data0),
    .busy(busy0), .done(done0)
  );

  flash_sdram_loader #(
    .FLASH_BASE(24'h000000), .LEN(24'd2), .DST_BASE(25'h1FFFFFF)
  ) u1 (
    .C25M(clk), .nRES(nres), .start(start),
    .nFCS(fcs1), .FCK(fck1), .MOSI(mosi1), .MISO(miso1),
    .wr_valid(valid1), .wr_ready(ready1), .wr_addr(addr1), .wr_data(data1),
    .busy(busy1), .done(done1)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks = checks + 1;
    if (got === want) passes = passes + 1;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  function automatic logic [7:0] flash_byte(input int id, input int idx);
    case (id * 8 + idx)
      0:       return 8'hA5;
      1:       return 8'h3C;
      2:       return 8'h96;
      3:       return 8'h0F;
      8:       return 8'h5A;
      9:       return 8'hC3;
      default: return 8'h00;
    endcase
  endfunction

  task automatic flash_step(input int id, input logic cs_n, input logic sck, input logic si,
                            input logic [31:0] want_cmd, inout flash_t f);
    logic [7:0] b;
    logic [2:0] sel;
    int         bi;
    if (cs_n === 1'b1) begin
      f.rises = 0;
      f.falls = 0;
      f.miso  = 1'b0;
    end else begin
      if (sck === 1'b1 && f.fck_d === 1'b0) begin
        if (f.rises < 32) f.cmd = {f.cmd[30:0], si};
        f.rises = f.rises + 1;
        if (f.rises == 32) check($sformatf("cmd%0d", id), 64'(f.cmd), 64'(want_cmd));
      end
      if (sck === 1'b0 && f.fck_d === 1'b1) begin
        f.falls = f.falls + 1;
        if (f.falls >= 32) begin
          bi     = f.falls - 32;
          b      = flash_byte(id, bi / 8);
          sel    = 3'(7 - bi % 8);
          f.miso = b[sel];
        end
      end
    end
    f.fck_d = sck;
  endtask

  task automatic mon_step(input int id, input logic v, input logic r,
                          input logic [24:0] a, input logic [7:0] d);
    logic [32:0] item;
    int          n;
    if (!(nres === 1'b1 && v === 1'b1 && r === 1'b1)) return;
    n = (id == 0) ? exp0.size() : exp1.size();
    if (n == 0) begin
      checks = checks + 1;
      $display("FAIL extra_byte%0d: got addr=%h data=%h, expected no transfer", id, a, d);
    end else begin
      if (id == 0) item = exp0.pop_front();
      else         item = exp1.pop_front();
      check($sformatf("sb%0d", id), 64'({a, d}), 64'(item));
    end
  endtask

  // Flash models: capture the command on rising FCK, shift data out after each falling FCK
  initial begin
    fl0 = '{0, 0, 32'd0, 1'b0, 1'b0};
    fl1 = '{0, 0, 32'd0, 1'b0, 1'b0};
    forever begin
      @(negedge clk);
      flash_step(0, fcs0, fck0, mosi0, 32'h03012345, fl0);
      flash_step(1, fcs1, fck1, mosi1, 32'h03000000, fl1);
      miso0 = fl0.miso;
      miso1 = fl1.miso;
    end
  end

  // Scoreboard monitor: every handshake pops and compares one expected byte
  initial forever begin
    @(negedge clk);
    mon_step(0, valid0, ready0, addr0, data0);
    mon_step(1, valid1, ready1, addr1, data1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    cur = cur + n;
  endtask

  task automatic at_edge(input int e);
    step(e - cur);
  endtask

  task automatic kick();
    cur   = 0;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic push_all();
    exp0.push_back({25'h1000000, 8'hA5});
    exp0.push_back({25'h1000001, 8'h3C});
    exp0.push_back({25'h1000002, 8'h96});
    exp0.push_back({25'h1000003, 8'h0F});
    exp1.push_back({25'h1FFFFFF, 8'h5A});
    exp1.push_back({25'h0000000, 8'hC3});
  endtask

  task automatic check_cmd_start(input string tag);
    check({tag, "_e1_ncs"},  64'(fcs0),  64'(1'b0));
    check({tag, "_e1_mosi"}, 64'(mosi0), 64'(1'b0));
    check({tag, "_e1_fck"},  64'(fck0),  64'(1'b0));
    at_edge(12);
    check({tag, "_e12_mosi"}, 64'(mosi0), 64'(1'b0));
    at_edge(13);
    check({tag, "_e13_mosi"}, 64'(mosi0), 64'(1'b1));
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (done0 === 1'b1 && done1 === 1'b1) break;
      step(1);
    end
    check({tag, "_done0"}, 64'(done0), 64'(1'b1));
    check({tag, "_done1"}, 64'(done1), 64'(1'b1));
    step(2);
    check({tag, "_sb0_empty"}, 64'(exp0.size()), 64'(0));
    check({tag, "_sb1_empty"}, 64'(exp1.size()), 64'(0));
  endtask

  initial begin
    // Reset state
    nres = 1'b0;
    step(3);
    check("rst_ncs",   64'(fcs0),   64'(1'b1));
    check("rst_fck",   64'(fck0),   64'(1'b0));
    check("rst_mosi",  64'(mosi0),  64'(1'b0));
    check("rst_valid", 64'(valid0), 64'(1'b0));
    check("rst_addr",  64'(addr0),  64'(25'h1000000));
    check("rst_data",  64'(data0),  64'(8'h00));
    check("rst_busy",  64'(busy0),  64'(1'b0));
    check("rst_done",  64'(done0),  64'(1'b0));
    nres = 1'b1;
    step(2);

    // Run 1: free-flowing copy, edge-exact timeline
    push_all();
    kick();
    check("r1_busy0", 64'(busy0), 64'(1'b1));
    check("r1_busy1", 64'(busy1), 64'(1'b1));
    check_cmd_start("r1");
    at_edge(80);
    check("r1_e80_valid", 64'(valid0), 64'(1'b0));
    at_edge(81);
    check("r1_e81_valid", 64'(valid0), 64'(1'b1));
    check("r1_e81_data",  64'(data0),  64'(8'hA5));
    at_edge(97);
    check("r1_e97_done1", 64'(done1), 64'(1'b0));
    at_edge(98);
    check("r1_e98_done1", 64'(done1), 64'(1'b1));
    at_edge(129);
    check("r1_e129_done", 64'(done0), 64'(1'b0));
    at_edge(130);
    check("r1_e130_done", 64'(done0), 64'(1'b1));
    check("r1_e130_ncs",  64'(fcs0),  64'(1'b1));
    check("r1_e130_busy", 64'(busy0), 64'(1'b0));
    step(3);
    check("r1_sb0_empty", 64'(exp0.size()), 64'(0));
    check("r1_sb1_empty", 64'(exp1.size()), 64'(0));

    // Run 2: downstream stall for 40 cycles after the first byte
    push_all();
    kick();
    check("r2_done_cleared", 64'(done0), 64'(1'b0));
    at_edge(81);
    ready0 = 1'b0;
    viol   = 0;
    for (int e = 82; e <= 121; e++) begin
      at_edge(e);
      if (e == 96) check("r2_e96_fck_high", 64'(fck0), 64'(1'b1));
      if (e >= 98 && (fck0 !== 1'b0 || data0 !== 8'hA5 || valid0 !== 1'b1 || fcs0 !== 1'b0))
        viol = viol + 1;
    end
    check("r2_stall_hold", 64'(viol), 64'(0));
    ready0 = 1'b1;
    wait_done("r2");

    // Run 3: reset while shifting data
    push_all();
    kick();
    at_edge(90);
    check("r3_e90_busy", 64'(busy0), 64'(1'b1));
    nres = 1'b0;
    step(1);
    check("r3_rst_ncs",   64'(fcs0),   64'(1'b1));
    check("r3_rst_fck",   64'(fck0),   64'(1'b0));
    check("r3_rst_valid", 64'(valid0), 64'(1'b0));
    check("r3_rst_busy",  64'(busy0),  64'(1'b0));
    check("r3_rst_done",  64'(done0),  64'(1'b0));
    check("r3_rst_addr",  64'(addr0),  64'(25'h1000000));
    nres = 1'b1;
    exp0.delete();
    exp1.delete();
    step(2);

    // Run 4: reset during the command, then a clean restart
    kick();
    at_edge(20);
    nres = 1'b0;
    step(1);
    check("r4_rst_ncs", 64'(fcs0), 64'(1'b1));
    nres = 1'b1;
    step(2);
    push_all();
    kick();
    check_cmd_start("r4");
    wait_done("r4");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
